writeback_unit: RTL and testbench
=================================

Name: writeback_unit

Overview:
- Final pipeline stage, directly downstream of the memory stage; captures the instruction, tag and PC that the memory stage forwards.
- Squashes wrong-path instructions by comparing each instruction's branch tag against the global branch reference.
- Generates the register-file load write port controls (port 2), latches halt, and counts retired instructions.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.
- NOP_INSTR, 32'hF000_0000, bubble encoding (cond = 4'b1111); loaded on reset and on squash.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- instr_in  in  32  instruction from memory stage.
- branch_in  in  1  branch tag carried with instr_in.
- pc_in  in  7  PC of instr_in.
- branch_ref_global  in  1  current branch reference (already updated for a branch resolving this cycle).
- stall  in  1  hold the stage register; no capture, no retire.
- instr_output  out  32  registered instruction (NOP_INSTR when squashed).
- pc_out  out  7  registered PC.
- rd  out  4  instr_output[15:12].
- w_en2  out  1  register-file port-2 write enable (load data).
- sel_w_data  out  1  1 = port-2 data from memory read data, 0 = ALU result.
- valid  out  1  registered instruction is live (not squashed, not bubble).
- is_halt  out  1  sticky halt flag.
- retire_count  out  CNT_W  retired live instructions, saturating.

Behaviour:
- Field decode of the registered instruction: cond = [31:28], opcode = [27:21], rd = [15:12].
- Reset (async, rst_n low):
  - instr register = NOP_INSTR, pc_out = 0, tag = 0.
  - valid = 0, w_en2 = 0, sel_w_data = 0, is_halt = 0, retire_count = 0.
  - State = RUN.
  - Reset mid-operation discards the held instruction and any halt.
- Capture, 1-cycle latency, only when stall = 0 and state = RUN:
  - Register instr_in, pc_in and branch_in.
  - If branch_in != branch_ref_global at the capture edge, store NOP_INSTR and valid = 0 (squash).
  - Otherwise valid = 1, unless instr_in[31:28] == 4'b1111, in which case valid = 0.
- stall = 1: all registers hold, counter holds, outputs unchanged. A stall asserted while valid is high does not re-retire the held instruction.
- Combinational outputs from the registered instruction:
  - Load is opcode[6:3] == 4'b1000, or opcode[6:5] == 2'b11 with opcode[4] == 0.
  - w_en2 = valid & load & ~stall.
  - sel_w_data = load.
  - Stores, branches, data-processing and HALT give w_en2 = 0.
- Retire counter: increments by 1 on each edge where valid = 1 and stall = 0. Saturates at all-ones; no wrap.
- State machine:
  - RUN: on an edge with stall = 0 and the registered instruction valid with opcode == 7'b0101010 (HALT), go to HALTED and set is_halt = 1. The HALT counts as retired.
  - HALTED: instr register forced to NOP_INSTR, valid = 0, inputs ignored, counter frozen. Exit only via reset.
- Simultaneous events:
  - Squash and stall in the same cycle: stall wins, register holds, and the squash is re-evaluated at the next non-stalled capture.
  - Tag flips on the same edge a HALT retires: the halt still takes effect.

Test Plan:
- Reset then 3 captures with branch_in = branch_ref_global = 0 (ADD, LDR rd = 4'd5, STR) -> valid = 1 each. w_en2 = 1 with rd = 5 only on the LDR cycle. retire_count = 3.
- branch_ref_global toggles to 1 while two instructions with tag 0 arrive -> both captured as NOP_INSTR with valid = 0. The next tag-1 instruction gives valid = 1; retire_count advances by 1 only.
- LDR held under stall = 1 for 4 cycles -> w_en2 = 0 throughout the stall. Then w_en2 = 1 for exactly one cycle after stall drops; retire_count +1.
- HALT captured valid -> is_halt = 1 one edge later. Following inputs are ignored, retire_count is frozen and valid stays 0 for 10 cycles.
- rst_n pulsed low mid-LDR, asynchronously between edges -> outputs immediately return to reset values: w_en2 = 0, is_halt = 0, retire_count = 0.
- Force retire_count near max with CNT_W = 4: 17 live instructions -> count sticks at 4'hF.

Source files
------------

// File: rtl/writeback_unit.sv
// Writeback stage: captures memory-stage output, squashes wrong-path work,
// drives register-file port-2 load controls, halts and counts retirements.
module writeback_unit #(
  parameter int          CNT_W     = 16,
  parameter logic [31:0] NOP_INSTR = 32'hF000_0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instr_in,
  input  logic             branch_in,
  input  logic [6:0]       pc_in,
  input  logic             branch_ref_global,
  input  logic             stall,
  output logic [31:0]      instr_output,
  output logic [6:0]       pc_out,
  output logic [3:0]       rd,
  output logic             w_en2,
  output logic             sel_w_data,
  output logic             valid,
  output logic             is_halt,
  output logic [CNT_W-1:0] retire_count
);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_e;

  localparam logic [6:0] OP_HALT = 7'b0101010;

  state_e            state_q, state_d;
  logic [31:0]       instr_q, instr_d;
  logic [6:0]        pc_q, pc_d;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [6:0] opcode;
  logic       load;
  logic       halt_ret;

  assign opcode   = instr_q[27:21];
  assign load     = (opcode[6:3] == 4'b1000) ||
                    ((opcode[6:5] == 2'b11) && !opcode[4]);
  assign halt_ret = valid_q && (opcode == OP_HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (!stall) begin
      unique case (state_q)
        RUN: begin
          if (valid_q && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + CNT_W'(1);
          // A retiring HALT wins over whatever is arriving this edge
          if (halt_ret) begin
            state_d = HALTED;
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
          end else begin
            pc_d = pc_in;
            if (branch_in != branch_ref_global) begin
              instr_d = NOP_INSTR;
              valid_d = 1'b0;
            end else begin
              instr_d = instr_in;
              valid_d = (instr_in[31:28] != 4'b1111);
            end
          end
        end
        HALTED: begin
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  assign instr_output = instr_q;
  assign pc_out       = pc_q;
  assign rd           = instr_q[15:12];
  assign valid        = valid_q;
  assign sel_w_data   = load;
  assign w_en2        = valid_q && load && !stall;
  assign is_halt      = (state_q == HALTED);
  assign retire_count = cnt_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: expected post-edge state is queued
// when stimulus is driven and compared once the capture edge has passed.
module tb_writeback_unit;

  localparam int          CW  = 4;
  localparam logic [31:0] NOP = 32'hF000_0000;
  localparam logic [6:0]  OP_ADD  = 7'b0000100;
  localparam logic [6:0]  OP_LDR  = 7'b1000000;
  localparam logic [6:0]  OP_STR  = 7'b1001000;
  localparam logic [6:0]  OP_HALT = 7'b0101010;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   instr_in;
  logic          branch_in;
  logic [6:0]    pc_in;
  logic          branch_ref_global;
  logic          stall;
  logic [31:0]   instr_output;
  logic [6:0]    pc_out;
  logic [3:0]    rd;
  logic          w_en2;
  logic          sel_w_data;
  logic          valid;
  logic          is_halt;
  logic [CW-1:0] retire_count;

  writeback_unit #(.CNT_W(CW)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .instr_in          (instr_in),
    .branch_in         (branch_in),
    .pc_in             (pc_in),
    .branch_ref_global (branch_ref_global),
    .stall             (stall),
    .instr_output      (instr_output),
    .pc_out            (pc_out),
    .rd                (rd),
    .w_en2             (w_en2),
    .sel_w_data        (sel_w_data),
    .valid             (valid),
    .is_halt           (is_halt),
    .retire_count      (retire_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]   instr;
    logic [6:0]    pc;
    logic          valid;
    logic          w_en2;
    logic          sel;
    logic          halt;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0]   m_instr;
  logic [6:0]    m_pc;
  logic          m_valid;
  logic          m_halt;
  logic [CW-1:0] m_cnt;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic is_ld(input logic [31:0] ins);
    logic [6:0] op;
    op = ins[27:21];
    return (op[6:3] == 4'b1000) || (op[6:5] == 2'b11 && !op[4]);
  endfunction

  function automatic logic [31:0] mk(input logic [3:0] c,
                                     input logic [6:0] op,
                                     input logic [3:0] r);
    return {c, op, 5'd0, r, 12'h000};
  endfunction

  task automatic m_reset();
    m_instr = NOP;
    m_pc    = '0;
    m_valid = 1'b0;
    m_halt  = 1'b0;
    m_cnt   = '0;
  endtask

  // Drive one cycle's inputs, check the pre-edge port-2 enable, queue the
  // expected post-edge state, then pop and compare after the edge.
  task automatic cyc(input logic [31:0] ins, input logic tg, input logic rf,
                     input logic [6:0] pc, input logic st);
    exp_t e;
    instr_in = ins;
    branch_in = tg;
    branch_ref_global = rf;
    pc_in = pc;
    stall = st;
    #1;
    chk("w_en2_pre", {31'd0, w_en2},
        {31'd0, m_valid & is_ld(m_instr) & ~st});
    if (!st && !m_halt) begin
      if (m_valid && m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
      if (m_valid && m_instr[27:21] == OP_HALT) begin
        m_halt = 1'b1;
        m_instr = NOP;
        m_valid = 1'b0;
      end else begin
        m_pc = pc;
        if (tg != rf) begin
          m_instr = NOP;
          m_valid = 1'b0;
        end else begin
          m_instr = ins;
          m_valid = (ins[31:28] != 4'hF);
        end
      end
    end else if (!st && m_halt) begin
      m_instr = NOP;
      m_valid = 1'b0;
    end
    e.instr = m_instr;
    e.pc    = m_pc;
    e.valid = m_valid;
    e.sel   = is_ld(m_instr);
    e.w_en2 = m_valid & is_ld(m_instr) & ~st;
    e.halt  = m_halt;
    e.cnt   = m_cnt;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("instr", instr_output, e.instr);
    chk("pc", {25'd0, pc_out}, {25'd0, e.pc});
    chk("rd", {28'd0, rd}, {28'd0, e.instr[15:12]});
    chk("valid", {31'd0, valid}, {31'd0, e.valid});
    chk("w_en2", {31'd0, w_en2}, {31'd0, e.w_en2});
    chk("sel_w_data", {31'd0, sel_w_data}, {31'd0, e.sel});
    chk("is_halt", {31'd0, is_halt}, {31'd0, e.halt});
    chk("retire_count", {28'd0, retire_count}, {28'd0, e.cnt});
  endtask

  initial begin
    rst_n = 1'b0;
    instr_in = '0;
    branch_in = 1'b0;
    pc_in = '0;
    branch_ref_global = 1'b0;
    stall = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_instr", instr_output, NOP);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_cnt", {28'd0, retire_count}, 32'd0);
    chk("rst_halt", {31'd0, is_halt}, 32'd0);
    chk("rst_w_en2", {31'd0, w_en2}, 32'd0);
    rst_n = 1'b1;

    // Three live captures; only the LDR raises w_en2
    cyc(mk(4'hE, OP_ADD, 4'd1), 1'b0, 1'b0, 7'd1, 1'b0);
    cyc(mk(4'hE, OP_LDR, 4'd5), 1'b0, 1'b0, 7'd2, 1'b0);
    chk("ldr_w_en2", {31'd0, w_en2}, 32'd1);
    chk("ldr_rd", {28'd0, rd}, 32'd5);
    cyc(mk(4'hE, OP_STR, 4'd6), 1'b0, 1'b0, 7'd3, 1'b0);
    chk("str_w_en2", {31'd0, w_en2}, 32'd0);
    cyc(NOP, 1'b0, 1'b0, 7'd4, 1'b0);
    chk("cnt_three", {28'd0, retire_count}, 32'd3);

    // Wrong-path tags are squashed; the next on-path instruction retires
    cyc(mk(4'hE, OP_ADD, 4'd2), 1'b0, 1'b1, 7'd5, 1'b0);
    chk("squash0", instr_output, NOP);
    cyc(mk(4'hE, OP_LDR, 4'd3), 1'b0, 1'b1, 7'd6, 1'b0);
    cyc(mk(4'hE, OP_ADD, 4'd4), 1'b1, 1'b1, 7'd7, 1'b0);
    chk("tag1_valid", {31'd0, valid}, 32'd1);
    cyc(NOP, 1'b1, 1'b1, 7'd8, 1'b0);
    chk("cnt_four", {28'd0, retire_count}, 32'd4);

    // LDR held under stall, including a squash-looking input that must wait
    cyc(mk(4'hE, OP_LDR, 4'd9), 1'b1, 1'b1, 7'd9, 1'b0);
    for (int i = 0; i < 4; i++)
      cyc(mk(4'hE, OP_ADD, 4'd7), 1'b0, 1'b1, 7'd10, 1'b1);
    cyc(mk(4'hE, OP_ADD, 4'd7), 1'b1, 1'b1, 7'd11, 1'b0);
    chk("cnt_after_stall", {28'd0, retire_count}, 32'd5);

    // HALT retires, then everything is frozen
    cyc(mk(4'hE, OP_HALT, 4'd0), 1'b1, 1'b1, 7'd12, 1'b0);
    cyc(mk(4'hE, OP_ADD, 4'd1), 1'b1, 1'b0, 7'd13, 1'b0);
    chk("halt_set", {31'd0, is_halt}, 32'd1);
    for (int i = 0; i < 10; i++)
      cyc(mk(4'hE, OP_LDR, 4'(i)), 1'b0, 1'b0, 7'(20 + i), 1'(i % 2));
    chk("halt_cnt", {28'd0, retire_count}, 32'd7);

    // Async reset between edges clears the halt and a live LDR
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_halt", {31'd0, is_halt}, 32'd0);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(mk(4'hE, OP_LDR, 4'd5), 1'b0, 1'b0, 7'd40, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_w_en2", {31'd0, w_en2}, 32'd0);
    chk("arst_cnt", {28'd0, retire_count}, 32'd0);
    chk("arst_instr", instr_output, NOP);
    chk("arst_halt2", {31'd0, is_halt}, 32'd0);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Saturation: 17 live instructions on a 4-bit counter
    for (int i = 0; i < 17; i++)
      cyc(mk(4'hE, OP_ADD, 4'(i)), 1'b0, 1'b0, 7'(i), 1'b0);
    cyc(NOP, 1'b0, 1'b0, 7'd0, 1'b0);
    chk("sat", {28'd0, retire_count}, 32'hF);

    if (exp_q.size() != 0) chk("queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
